result_queue: RTL and testbench

Expected-result FIFO that sits between the golden-model side of the verify platform and the scoreboard. The golden model pushes one 128-bit expected ciphertext per stimulus issued to the chip. The scoreboard pops one entry per `generator_require` pulse and compares it in the same cycle against the chip result. The queue absorbs the chip's processing latency and flags any loss of stimulus/result alignment.

---
 rtl/result_queue.sv | 93 +++++++++
 tb/tb_result_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/result_queue.sv
// result_queue: expected-result FIFO between the golden model and the scoreboard.
// Show-ahead head output, separate occupancy counter, sticky overflow/underflow
// flags and running push/pop totals. Storage array is intentionally not reset.
module result_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [127:0]  push_data,
  input  logic          generator_require,
  output logic [127:0]  generator_result,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic [31:0]   pushed_total,
  output logic [31:0]   popped_total
);

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  // A pop frees a slot in the same cycle, so a push into a full queue still lands.
  always_comb begin
    pop_ok  = generator_require & ~empty;
    push_ok = push & (~full | pop_ok);
  end

  // Status and head output derive from registers only.
  always_comb begin
    full             = (count == FULL_COUNT);
    empty            = (count == '0);
    generator_result = empty ? '0 : mem[rd_ptr];
  end

  // Storage write; no reset so the array maps onto plain registers.
  always_ff @(posedge clk) begin
    if (!clear && push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, sticky flags and totals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      pushed_total <= '0;
      popped_total <= '0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      pushed_total <= '0;
      popped_total <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr       <= wr_ptr + 1'b1;
        pushed_total <= pushed_total + 32'd1;
      end
      if (pop_ok) begin
        rd_ptr       <= rd_ptr + 1'b1;
        popped_total <= popped_total + 32'd1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
      if (push && full && !pop_ok) begin
        overflow <= 1'b1;
      end
      if (generator_require && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_queue.sv
// Testbench for result_queue: scoreboard queue of expected values plus a
// reference occupancy/flag/total model, compared on the falling clock edge.
module tb_result_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          push = 1'b0;
  logic [127:0]  push_data = '0;
  logic          generator_require = 1'b0;
  logic [127:0]  generator_result;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic [31:0]   pushed_total;
  logic [31:0]   popped_total;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [127:0] sb[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;
  int unsigned  m_pushed = 0;
  int unsigned  m_popped = 0;

  result_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .push(push),
    .push_data(push_data),
    .generator_require(generator_require),
    .generator_result(generator_result),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow),
    .pushed_total(pushed_total),
    .popped_total(popped_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_pushed = 0;
    m_popped = 0;
  endtask

  // Compare every status output against the model at the current time.
  task automatic check_now(input string tag);
    int unsigned n;
    n = sb.size();
    check({tag, ".count"}, 128'(count), 128'(n));
    check({tag, ".full"}, 128'(full), 128'(n == DEPTH));
    check({tag, ".empty"}, 128'(empty), 128'(n == 0));
    check({tag, ".ovf"}, 128'(overflow), 128'(m_ovf));
    check({tag, ".unf"}, 128'(underflow), 128'(m_unf));
    check({tag, ".pushed"}, 128'(pushed_total), 128'(m_pushed));
    check({tag, ".popped"}, 128'(popped_total), 128'(m_popped));
    if (n == 0) check({tag, ".head0"}, generator_result, '0);
    else        check({tag, ".head"}, generator_result, sb[0]);
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check_now(tag);
  endtask

  // One clock cycle with optional push and pop; model updated from its own queue.
  task automatic cyc(input logic p, input logic [127:0] d, input logic r);
    bit pop_ok;
    bit push_ok;
    @(negedge clk);
    push = p;
    push_data = d;
    generator_require = r;
    pop_ok  = r && (sb.size() > 0);
    push_ok = p && ((sb.size() < DEPTH) || pop_ok);
    if (r && !pop_ok) m_unf = 1'b1;
    if (p && !push_ok) m_ovf = 1'b1;
    if (pop_ok) begin
      check("pop_data", generator_result, sb.pop_front());
      m_popped++;
    end
    if (push_ok) begin
      sb.push_back(d);
      m_pushed++;
    end
    @(posedge clk);
    #1;
    push = 1'b0;
    generator_require = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    push = 1'b1;
    push_data = 128'hDEAD;
    generator_require = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    push = 1'b0;
    generator_require = 1'b0;
    model_reset();
  endtask

  initial begin
    // Reset state
    #2;
    check_now("reset");
    #20;
    rst_n = 1'b1;
    check_status("after_reset");

    // Basic order
    cyc(1'b1, 128'h1, 1'b0);
    cyc(1'b1, 128'h2, 1'b0);
    cyc(1'b1, 128'h3, 1'b0);
    check_status("basic_loaded");
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    check_status("basic_drained");
    check("basic_pushed3", 128'(pushed_total), 128'd3);
    check("basic_popped3", 128'(popped_total), 128'd3);

    // Fill and overflow
    do_clear();
    for (int i = 0; i < 17; i++) cyc(1'b1, 128'(32'h100 + i), 1'b0);
    check_status("fill");
    check("fill_full", 128'(full), 128'd1);
    check("fill_count", 128'(count), 128'd16);
    check("fill_ovf", 128'(overflow), 128'd1);
    check("fill_pushed", 128'(pushed_total), 128'd16);
    for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1);
    check_status("fill_drained");

    // Full with simultaneous push/pop
    do_clear();
    for (int i = 0; i < 16; i++) cyc(1'b1, 128'(32'h200 + i), 1'b0);
    cyc(1'b1, 128'hABCD_0000_0000_0000_0000_0000_0000_1234, 1'b1);
    check_status("fullpp");
    check("fullpp_count", 128'(count), 128'd16);
    check("fullpp_ovf", 128'(overflow), 128'd0);
    for (int i = 0; i < 15; i++) cyc(1'b0, '0, 1'b1);
    check("fullpp_x_head", generator_result, 128'hABCD_0000_0000_0000_0000_0000_0000_1234);
    cyc(1'b0, '0, 1'b1);
    check_status("fullpp_drained");

    // Empty underflow
    do_clear();
    cyc(1'b0, '0, 1'b1);
    check_status("unf_pop");
    check("unf_flag", 128'(underflow), 128'd1);
    cyc(1'b1, 128'h5A5A, 1'b1);
    check_status("unf_pp");
    check("unf_popped0", 128'(popped_total), 128'd0);
    check("unf_count1", 128'(count), 128'd1);
    check("unf_headY", generator_result, 128'h5A5A);

    // Wrap-around with occupancy 3
    do_clear();
    for (int i = 0; i < 3; i++) cyc(1'b1, 128'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      check("wrap_head", generator_result, 128'(i));
      cyc(1'b1, 128'(i + 3), 1'b1);
    end
    check_status("wrap");
    check("wrap_flags", 128'({overflow, underflow}), 128'd0);

    // Clear with 5 entries and overflow set
    do_clear();
    for (int i = 0; i < 17; i++) cyc(1'b1, 128'(32'h300 + i), 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b0, '0, 1'b1);
    check_status("pre_clear");
    do_clear();
    check_status("post_clear");
    cyc(1'b1, 128'h7777, 1'b0);
    check_status("clear_push");
    check("clear_head", generator_result, 128'h7777);

    // Asynchronous reset mid-stream
    cyc(1'b1, 128'h8888, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now("async_reset");
    #12;
    rst_n = 1'b1;
    check_status("after_reset2");
    cyc(1'b1, 128'h9999, 1'b0);
    check_status("reset_push");
    check("reset_head", generator_result, 128'h9999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
